// File: rtl/aes_masked_pkg.sv
// Shared constants and helpers for the masked AES datapath.
// Share j of bit b in a shared byte lives at bit [8*j+b].
package aes_masked_pkg;

  localparam int BYTES_PER_COL  = 4;
  localparam int COLS_PER_STATE = 4;

  typedef logic [$clog2(BYTES_PER_COL)-1:0]  row_idx_t;
  typedef logic [$clog2(COLS_PER_STATE)-1:0] col_idx_t;

  function automatic int SH_BYTE_W(input int d);
    return 8 * d;
  endfunction

endpackage

// File: rtl/mc_col_slot.sv
// One column buffer for the MixColumns collector: shared column data,
// column tag, bypass flag and a full flag. Pure share-wise storage.
module mc_col_slot
  import aes_masked_pkg::*;
#(
  parameter int d = 2
) (
  input  logic                                      clk,
  input  logic                                      clr,
  input  logic [BYTES_PER_COL-1:0]                  row_we,
  input  logic [SH_BYTE_W(d)-1:0]                   byte_in,
  input  logic                                      tag_we,
  input  col_idx_t                                  col_in,
  input  logic                                      bypass_in,
  input  logic                                      set_full,
  input  logic                                      clr_full,
  output logic [BYTES_PER_COL*SH_BYTE_W(d)-1:0]     data,
  output col_idx_t                                  col_tag,
  output logic                                      bypass,
  output logic                                      full
);

  localparam int BW = SH_BYTE_W(d);

  // Clearing the data on reset keeps stale shares from ever reaching the output mux.
  always_ff @(posedge clk) begin
    if (clr) begin
      data    <= '0;
      col_tag <= '0;
      bypass  <= 1'b0;
      full    <= 1'b0;
    end else begin
      for (int r = 0; r < BYTES_PER_COL; r++) begin
        if (row_we[r]) data[BW*r +: BW] <= byte_in;
      end
      if (tag_we) begin
        col_tag <= col_in;
        bypass  <= bypass_in;
      end
      if (set_full)      full <= 1'b1;
      else if (clr_full) full <= 1'b0;
    end
  end

endmodule

// File: rtl/mc_column_collector.sv
// Byte-serial to column-parallel collector feeding masked MixColumns.
// Two ping-pong column slots let the byte stream continue while a column drains.
module mc_column_collector
  import aes_masked_pkg::*;
#(
  parameter int d = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [SH_BYTE_W(d)-1:0]               sh_byte_in,
  input  logic                                  in_bypass_mc,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [BYTES_PER_COL*SH_BYTE_W(d)-1:0] sh_4bytes_to_MC,
  output col_idx_t                              out_col_idx,
  output logic                                  out_bypass_mc,
  output logic                                  out_last_col
);

  localparam int       COL_W    = BYTES_PER_COL * SH_BYTE_W(d);
  localparam row_idx_t LAST_ROW = row_idx_t'(BYTES_PER_COL - 1);
  localparam col_idx_t LAST_COL = col_idx_t'(COLS_PER_STATE - 1);

  row_idx_t byte_cnt;
  col_idx_t wr_col;
  logic     wr_slot;
  logic     rd_slot;

  logic     accept;
  logic     deliver;

  logic [BYTES_PER_COL-1:0] row_we [2];
  logic [1:0]               tag_we;
  logic [1:0]               set_full;
  logic [1:0]               clr_full;

  logic [COL_W-1:0] slot_data [2];
  col_idx_t         slot_col  [2];
  logic [1:0]       slot_byp;
  logic [1:0]       slot_full;

  // in_ready looks only at slot state, never at out_ready, so a freed slot opens next cycle.
  assign in_ready  = !slot_full[wr_slot];
  assign out_valid = slot_full[rd_slot];
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;

  always_comb begin
    for (int s = 0; s < 2; s++) row_we[s] = '0;
    tag_we   = '0;
    set_full = '0;
    clr_full = '0;
    if (accept) begin
      row_we[wr_slot]   = BYTES_PER_COL'(1) << byte_cnt;
      tag_we[wr_slot]   = (byte_cnt == '0);
      set_full[wr_slot] = (byte_cnt == LAST_ROW);
    end
    if (deliver) clr_full[rd_slot] = 1'b1;
  end

  for (genvar s = 0; s < 2; s++) begin : g_slot
    mc_col_slot #(.d(d)) u_slot (
      .clk       (clk),
      .clr       (rst),
      .row_we    (row_we[s]),
      .byte_in   (sh_byte_in),
      .tag_we    (tag_we[s]),
      .col_in    (wr_col),
      .bypass_in (in_bypass_mc),
      .set_full  (set_full[s]),
      .clr_full  (clr_full[s]),
      .data      (slot_data[s]),
      .col_tag   (slot_col[s]),
      .bypass    (slot_byp[s]),
      .full      (slot_full[s])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
      wr_col   <= '0;
      wr_slot  <= 1'b0;
      rd_slot  <= 1'b0;
    end else begin
      if (accept) begin
        byte_cnt <= byte_cnt + row_idx_t'(1);
        if (byte_cnt == LAST_ROW) begin
          wr_slot <= ~wr_slot;
          wr_col  <= wr_col + col_idx_t'(1);
        end
      end
      if (deliver) rd_slot <= ~rd_slot;
    end
  end

  assign sh_4bytes_to_MC = slot_data[rd_slot];
  assign out_col_idx     = slot_col[rd_slot];
  assign out_bypass_mc   = slot_byp[rd_slot];
  assign out_last_col    = (slot_col[rd_slot] == LAST_COL);

endmodule

// File: tb/tb_mc_column_collector.sv
// Self-checking bench for mc_column_collector (d=2): directed vector tables
// plus hand-written back-pressure, mid-column reset and overlap sequences.
module tb_mc_column_collector;

  localparam int D = 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [8*D-1:0]  sh_byte_in;
  logic          in_bypass_mc;
  logic          out_valid;
  logic          out_ready;
  logic [32*D-1:0] sh_4bytes_to_MC;
  logic [1:0]    out_col_idx;
  logic          out_bypass_mc;
  logic          out_last_col;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        in_valid;
    logic [7:0]  val;
    logic        byp;
    logic        ordy;
    logic        exp_ir;
    logic        exp_ov;
    logic [31:0] exp_col;
    logic [1:0]  exp_idx;
    logic        exp_byp;
    logic        exp_last;
  } vec_t;

  vec_t t2[6];
  vec_t t4[22];

  mc_column_collector #(.d(D)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .sh_byte_in      (sh_byte_in),
    .in_bypass_mc    (in_bypass_mc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .sh_4bytes_to_MC (sh_4bytes_to_MC),
    .out_col_idx     (out_col_idx),
    .out_bypass_mc   (out_bypass_mc),
    .out_last_col    (out_last_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [8*D-1:0] mask_byte(input logic [7:0] v);
    logic [7:0] m;
    m = 8'($urandom);
    return {v ^ m, m};
  endfunction

  function automatic logic [31:0] unmask_col(input logic [32*D-1:0] c);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = c[16*i +: 8] ^ c[16*i+8 +: 8];
    return r;
  endfunction

  function automatic vec_t mk(input logic v, input logic [7:0] val, input logic byp,
                              input logic ir, input logic ov, input logic [31:0] col,
                              input logic [1:0] idx, input logic eb, input logic el);
    vec_t x;
    x.in_valid = v;  x.val = val;   x.byp = byp;   x.ordy = 1'b1;
    x.exp_ir = ir;   x.exp_ov = ov; x.exp_col = col;
    x.exp_idx = idx; x.exp_byp = eb; x.exp_last = el;
    return x;
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [7:0] val,
                               input logic byp, input logic ordy);
    rst          = r;
    in_valid     = v;
    sh_byte_in   = mask_byte(val);
    in_bypass_mc = byp;
    out_ready    = ordy;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic runVec(input string tag, input vec_t v);
    applyStimulus(1'b0, v.in_valid, v.val, v.byp, v.ordy);
    checkOutput({tag, " in_ready"}, 32'(in_ready), 32'(v.exp_ir));
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'(v.exp_ov));
    if (v.exp_ov) begin
      checkOutput({tag, " column"}, unmask_col(sh_4bytes_to_MC), v.exp_col);
      checkOutput({tag, " col_idx"}, 32'(out_col_idx), 32'(v.exp_idx));
      checkOutput({tag, " bypass"}, 32'(out_bypass_mc), 32'(v.exp_byp));
      checkOutput({tag, " last_col"}, 32'(out_last_col), 32'(v.exp_last));
    end
    nextCycle();
  endtask

  initial begin
    logic [7:0]  bp_bytes [12];
    logic [31:0] bp_cols  [3];
    int          ptr;
    int          ncol;

    rst = 1'b1; in_valid = 1'b0; sh_byte_in = '0; in_bypass_mc = 1'b0; out_ready = 1'b0;

    // single column: rows db,13,53,45, available the cycle after the 4th byte
    t2[0] = mk(1, 8'hdb, 0, 1, 0, 32'h0, 0, 0, 0);
    t2[1] = mk(1, 8'h13, 0, 1, 0, 32'h0, 0, 0, 0);
    t2[2] = mk(1, 8'h53, 0, 1, 0, 32'h0, 0, 0, 0);
    t2[3] = mk(1, 8'h45, 0, 1, 0, 32'h0, 0, 0, 0);
    t2[4] = mk(0, 8'h00, 0, 1, 1, 32'h455313db, 0, 0, 0);
    t2[5] = mk(0, 8'h00, 0, 1, 0, 32'h0, 0, 0, 0);

    // full state plus wrap; bypass on row 1 of col 0 must be ignored
    t4[0]  = mk(1, 8'ha0, 0, 1, 0, 32'h0, 0, 0, 0);
    t4[1]  = mk(1, 8'ha1, 1, 1, 0, 32'h0, 0, 0, 0);
    t4[2]  = mk(1, 8'ha2, 0, 1, 0, 32'h0, 0, 0, 0);
    t4[3]  = mk(1, 8'ha3, 0, 1, 0, 32'h0, 0, 0, 0);
    t4[4]  = mk(1, 8'hb0, 0, 1, 1, 32'ha3a2a1a0, 0, 0, 0);
    t4[5]  = mk(1, 8'hb1, 0, 1, 0, 32'h0, 0, 0, 0);
    t4[6]  = mk(1, 8'hb2, 0, 1, 0, 32'h0, 0, 0, 0);
    t4[7]  = mk(1, 8'hb3, 0, 1, 0, 32'h0, 0, 0, 0);
    t4[8]  = mk(1, 8'hc0, 0, 1, 1, 32'hb3b2b1b0, 1, 0, 0);
    t4[9]  = mk(1, 8'hc1, 0, 1, 0, 32'h0, 0, 0, 0);
    t4[10] = mk(1, 8'hc2, 0, 1, 0, 32'h0, 0, 0, 0);
    t4[11] = mk(1, 8'hc3, 0, 1, 0, 32'h0, 0, 0, 0);
    t4[12] = mk(1, 8'hd0, 1, 1, 1, 32'hc3c2c1c0, 2, 0, 0);
    t4[13] = mk(1, 8'hd1, 0, 1, 0, 32'h0, 0, 0, 0);
    t4[14] = mk(1, 8'hd2, 0, 1, 0, 32'h0, 0, 0, 0);
    t4[15] = mk(1, 8'hd3, 0, 1, 0, 32'h0, 0, 0, 0);
    t4[16] = mk(1, 8'he0, 0, 1, 1, 32'hd3d2d1d0, 3, 1, 1);
    t4[17] = mk(1, 8'he1, 0, 1, 0, 32'h0, 0, 0, 0);
    t4[18] = mk(1, 8'he2, 0, 1, 0, 32'h0, 0, 0, 0);
    t4[19] = mk(1, 8'he3, 0, 1, 0, 32'h0, 0, 0, 0);
    t4[20] = mk(0, 8'h00, 0, 1, 1, 32'he3e2e1e0, 0, 0, 0);
    t4[21] = mk(0, 8'h00, 0, 1, 0, 32'h0, 0, 0, 0);

    @(posedge clk); #1;

    // reset state
    doReset();
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset col_idx", 32'(out_col_idx), 32'd0);
    checkOutput("reset bypass", 32'(out_bypass_mc), 32'd0);
    checkOutput("reset last_col", 32'(out_last_col), 32'd0);
    checkOutput("reset data", (sh_4bytes_to_MC == '0) ? 32'd1 : 32'd0, 32'd1);

    for (int i = 0; i < 6; i++) runVec($sformatf("single[%0d]", i), t2[i]);

    doReset();
    for (int i = 0; i < 22; i++) runVec($sformatf("wrap[%0d]", i), t4[i]);

    // back-pressure: 12 bytes offered with out_ready low, only 8 fit
    for (int i = 0; i < 12; i++) bp_bytes[i] = 8'(8'h30 + i);
    bp_cols[0] = 32'h33323130;
    bp_cols[1] = 32'h37363534;
    bp_cols[2] = 32'h3b3a3938;
    doReset();
    ptr = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      applyStimulus(1'b0, 1'b1, bp_bytes[ptr], 1'b0, 1'b0);
      checkOutput($sformatf("bp in_ready[%0d]", cyc), 32'(in_ready), (cyc < 8) ? 32'd1 : 32'd0);
      if (cyc >= 4) begin
        checkOutput($sformatf("bp hold valid[%0d]", cyc), 32'(out_valid), 32'd1);
        checkOutput($sformatf("bp hold col[%0d]", cyc), unmask_col(sh_4bytes_to_MC), bp_cols[0]);
      end
      if (in_ready) ptr++;
      nextCycle();
    end
    checkOutput("bp accepted", 32'(ptr), 32'd8);
    applyStimulus(1'b0, 1'b1, bp_bytes[ptr], 1'b0, 1'b1);
    checkOutput("bp ready indep of out_ready", 32'(in_ready), 32'd0);
    ncol = 0;
    for (int cyc = 0; cyc < 30 && ncol < 3; cyc++) begin
      applyStimulus(1'b0, ptr < 12, (ptr < 12) ? bp_bytes[ptr] : 8'h00, 1'b0, 1'b1);
      if (out_valid) begin
        checkOutput($sformatf("bp col%0d data", ncol), unmask_col(sh_4bytes_to_MC), bp_cols[ncol]);
        checkOutput($sformatf("bp col%0d idx", ncol), 32'(out_col_idx), 32'(ncol));
        checkOutput($sformatf("bp col%0d last", ncol), 32'(out_last_col), 32'd0);
        ncol++;
      end
      if (ptr < 12 && in_ready) ptr++;
      nextCycle();
    end
    checkOutput("bp columns delivered", 32'(ncol), 32'd3);

    // reset in the middle of a column discards the partial bytes
    doReset();
    applyStimulus(1'b0, 1'b1, 8'h11, 1'b0, 1'b1); nextCycle();
    applyStimulus(1'b0, 1'b1, 8'h22, 1'b0, 1'b1); nextCycle();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1); nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("midrst out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst data cleared", (sh_4bytes_to_MC == '0) ? 32'd1 : 32'd0, 32'd1);
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(i + 1), 1'b0, 1'b1);
      checkOutput($sformatf("midrst no column[%0d]", i), 32'(out_valid), 32'd0);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("midrst new valid", 32'(out_valid), 32'd1);
    checkOutput("midrst new column", unmask_col(sh_4bytes_to_MC), 32'h04030201);
    checkOutput("midrst new idx", 32'(out_col_idx), 32'd0);
    nextCycle();

    // completing slot1 while slot0 drains in the same cycle
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(8'h11 * (i + 1)), 1'b0, (i == 7));
      checkOutput($sformatf("sim in_ready[%0d]", i), 32'(in_ready), 32'd1);
      if (i == 7) begin
        checkOutput("sim col0 valid", 32'(out_valid), 32'd1);
        checkOutput("sim col0 data", unmask_col(sh_4bytes_to_MC), 32'h44332211);
      end
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("sim col1 valid", 32'(out_valid), 32'd1);
    checkOutput("sim col1 data", unmask_col(sh_4bytes_to_MC), 32'h88776655);
    checkOutput("sim col1 idx", 32'(out_col_idx), 32'd1);
    checkOutput("sim slot0 free", 32'(in_ready), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("sim col1 held", unmask_col(sh_4bytes_to_MC), 32'h88776655);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("sim drained", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
